// File: rtl/rv_pkg.sv
// Shared RISC-V front-end definitions: machine widths and the fetch-unit state encoding.
package rv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef enum logic [0:0] {
        ST_BOOT  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_e;

    // Instructions are 4-byte aligned, so restart targets drop their low two bits.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv_sync_fifo.sv
// Single-clock FIFO with flush; the head entry is visible combinationally on rdata_o.
module rv_sync_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // The consumer must see a new head one cycle after its push, so reads are not registered.
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/rv_fetch_buf.sv
// Instruction fetch unit: credit-limited requests to instruction memory, in-order
// response buffering, and redirect handling that discards responses already in flight.
module rv_fetch_buf
    import rv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            instr_ready_i
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;
    localparam int EW = XLEN + ILEN;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [CW-1:0]   occ;
    logic            fifo_full;
    logic            fifo_empty;
    logic [EW-1:0]   fifo_rdata;
    logic [SW-1:0]   credit_used;
    logic            gnt_fire;
    logic            rsp_drop;
    logic            push;
    logic            pop;

    // Every request in flight owns a buffer slot, so the buffer can never overflow.
    assign credit_used = SW'(outst_q) + SW'(occ);
    assign imem_req_o  = (state_q == ST_FETCH) && (credit_used < SW'(DEPTH));
    assign imem_addr_o = fetch_pc_q;

    assign gnt_fire = imem_req_o && imem_gnt_i;
    assign rsp_drop = imem_rvalid_i && (drop_q != '0);
    assign push     = imem_rvalid_i && !rsp_drop && !redirect_i && !fifo_full;
    assign pop      = instr_valid_o && instr_ready_i && !redirect_i;

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = fifo_empty ? '0 : fifo_rdata[ILEN-1:0];
    assign pc_o          = fifo_empty ? '0 : fifo_rdata[EW-1:ILEN];

    // Responses return in order and live ones follow the fetch stream contiguously,
    // so the address of the next live response is just a second running PC.
    always_comb begin
        state_d    = ST_FETCH;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outst_d    = outst_q + CW'(gnt_fire) - CW'(imem_rvalid_i);
        drop_d     = drop_q;
        if (redirect_i) begin
            fetch_pc_d = align_pc(redirect_pc_i);
            rsp_pc_d   = align_pc(redirect_pc_i);
            drop_d     = outst_d;
        end else begin
            if (gnt_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (rsp_drop) drop_d = drop_q - CW'(1);
            if (push)     rsp_pc_d = rsp_pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    rv_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ibuf (
        .clk     (clk),
        .rstn    (rstn),
        .flush_i (redirect_i),
        .push_i  (push),
        .wdata_i ({rsp_pc_q, imem_rdata_i}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (occ)
    );

    a_rsp_has_outstanding: assert property (
        @(posedge clk) disable iff (!rstn) imem_rvalid_i |-> (outst_q != '0)
    );

endmodule

// File: tb/tb_rv_fetch_buf.sv
// Directed bench for rv_fetch_buf with a queue-based reference model and a reactive memory.
module tb_rv_fetch_buf;
    import rv_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        redirect_i = 1'b0;
    logic [63:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [63:0] pc_o;
    logic        instr_ready_i = 1'b0;

    always #5 clk = ~clk;

    rv_fetch_buf #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_ready_i (instr_ready_i)
    );

    typedef struct { logic [63:0] addr; int due; } mem_t;
    typedef struct { logic [63:0] addr; bit stale; } fl_t;
    typedef struct { int stp; logic [63:0] pc; } cons_t;

    mem_t        mem_q[$];
    fl_t         m_infl[$];
    logic [63:0] m_buf[$];
    logic [63:0] m_pc;
    bit          m_boot;
    cons_t       cons_log[$];

    int n_checks = 0;
    int n_err = 0;
    int stepn = 0;
    int n_grants = 0;
    int gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
    bit          redir_req = 1'b0;
    logic [63:0] redir_pc = '0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_0013;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step=%0d actual=%h expected=%h", name, stepn, act, exp);
        end
    endfunction

    // One clock cycle: compare against the model, drive inputs, advance memory and model.
    task automatic step();
        bit          exp_req, fire, live;
        logic [63:0] raddr;
        fl_t         h;
        int          lat;
        exp_req = !m_boot && ((m_infl.size() + m_buf.size()) < DEPTH);
        chk("req", 64'(imem_req_o), 64'(exp_req));
        if (exp_req) chk("addr", imem_addr_o, m_pc);
        chk("valid", 64'(instr_valid_o), 64'(m_buf.size() > 0));
        if (m_buf.size() > 0) begin
            chk("pc", pc_o, m_buf[0]);
            chk("instr", 64'(instr_o), 64'(mem_word(m_buf[0])));
        end

        imem_gnt_i    = ($urandom_range(0, 99) < gnt_pct);
        instr_ready_i = ($urandom_range(0, 99) < rdy_pct);
        redirect_i    = redir_req;
        redirect_pc_i = redir_pc;
        if (mem_q.size() > 0 && mem_q[0].due <= stepn) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mem_q[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'hDEAD_BEEF;
        end
        #1;

        if (imem_rvalid_i) void'(mem_q.pop_front());
        if (imem_req_o && imem_gnt_i) begin
            lat = $urandom_range(lat_min, lat_max);
            mem_q.push_back('{imem_addr_o, stepn + lat});
            n_grants++;
        end
        if (instr_valid_o && instr_ready_i && !redirect_i) cons_log.push_back('{stepn, pc_o});

        fire  = exp_req && imem_gnt_i;
        live  = 1'b0;
        raddr = '0;
        if (imem_rvalid_i) begin
            n_checks++;
            if (m_infl.size() == 0) begin
                n_err++;
                $display("FAIL rsp_outstanding step=%0d actual=0 required>=1", stepn);
            end else begin
                h     = m_infl.pop_front();
                live  = !h.stale;
                raddr = h.addr;
            end
        end
        if (fire) m_infl.push_back('{m_pc, redirect_i});
        if (redirect_i) begin
            foreach (m_infl[i]) m_infl[i].stale = 1'b1;
            m_buf.delete();
            m_pc = {redir_pc[63:2], 2'b00};
        end else begin
            if (m_buf.size() > 0 && instr_ready_i) void'(m_buf.pop_front());
            if (imem_rvalid_i && live) m_buf.push_back(raddr);
            if (fire) m_pc = m_pc + 64'd4;
        end
        m_boot    = 1'b0;
        redir_req = 1'b0;
        @(posedge clk);
        #1;
        stepn++;
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        redirect_i    = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        instr_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        mem_q.delete();
        m_infl.delete();
        m_buf.delete();
        cons_log.delete();
        m_pc     = RESET_PC;
        m_boot   = 1'b1;
        n_grants = 0;
        stepn    = 0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic redirect_seq(input string tag, input logic [63:0] target);
        int n;
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        repeat (8) step();
        chk({tag, "_pre_valid"}, 64'(instr_valid_o), 64'd1);
        chk({tag, "_pre_req"}, 64'(imem_req_o), 64'd1);
        redir_req = 1'b1;
        redir_pc  = target;
        n = cons_log.size();
        step();
        chk({tag, "_valid_after"}, 64'(instr_valid_o), 64'd0);
        chk({tag, "_drop_loaded"}, 64'(dut.drop_q), 64'd1);
        repeat (20) step();
        chk({tag, "_drop_zero"}, 64'(dut.drop_q), 64'd0);
        if (cons_log.size() >= n + 4) begin
            chk({tag, "_pc0"}, cons_log[n].pc, {target[63:2], 2'b00});
            chk({tag, "_pc1"}, cons_log[n + 1].pc, {target[63:2], 2'b00} + 64'd4);
            chk({tag, "_pc2"}, cons_log[n + 2].pc, {target[63:2], 2'b00} + 64'd8);
            chk({tag, "_pc3"}, cons_log[n + 3].pc, {target[63:2], 2'b00} + 64'd12);
        end else begin
            chk({tag, "_cons_count"}, 64'(cons_log.size() - n), 64'd4);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog step=%0d actual=timeout required=finish", stepn);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard, bad;

        // T1: reset state, first fetch and back-to-back delivery
        do_reset();
        chk("t1_rst_req", 64'(imem_req_o), 64'd0);
        chk("t1_rst_addr", imem_addr_o, RESET_PC);
        chk("t1_rst_valid", 64'(instr_valid_o), 64'd0);
        chk("t1_rst_instr", 64'(instr_o), 64'd0);
        chk("t1_rst_pc", pc_o, 64'd0);
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        step();
        chk("t1_req_cycle2", 64'(imem_req_o), 64'd1);
        chk("t1_addr_cycle2", imem_addr_o, 64'h0);
        repeat (8) step();
        chk("t1_s0", 64'(cons_log[0].stp), 64'd3);
        chk("t1_pc0", cons_log[0].pc, 64'h0);
        chk("t1_s1", 64'(cons_log[1].stp), 64'd4);
        chk("t1_pc1", cons_log[1].pc, 64'h4);
        chk("t1_s2", 64'(cons_log[2].stp), 64'd5);
        chk("t1_pc2", cons_log[2].pc, 64'h8);
        $display("T1 first-fetch done step=%0d", stepn);

        // T2: consumer stalled, credits stop requests at DEPTH
        do_reset();
        gnt_pct = 100; rdy_pct = 0; lat_min = 1; lat_max = 1;
        repeat (20) step();
        chk("t2_grants", 64'(n_grants), 64'd4);
        chk("t2_req_low", 64'(imem_req_o), 64'd0);
        chk("t2_model_occ", 64'(m_buf.size()), 64'd4);
        chk("t2_valid", 64'(instr_valid_o), 64'd1);
        rdy_pct = 100;
        repeat (30) step();
        chk("t2_cons_enough", 64'(cons_log.size() >= 8), 64'd1);
        bad = 0;
        for (int i = 0; i < cons_log.size(); i++) if (cons_log[i].pc != 64'(4 * i)) bad++;
        chk("t2_seq_breaks", 64'(bad), 64'd0);
        $display("T2 stall done step=%0d", stepn);

        // T3: redirect with three long-latency requests in flight
        do_reset();
        gnt_pct = 100; rdy_pct = 100; lat_min = 5; lat_max = 5;
        repeat (4) step();
        chk("t3_outstanding", 64'(dut.outst_q), 64'd3);
        gnt_pct   = 0;
        redir_req = 1'b1;
        redir_pc  = 64'h1002;
        step();
        chk("t3_addr", imem_addr_o, 64'h1000);
        chk("t3_req", 64'(imem_req_o), 64'd1);
        chk("t3_drop", 64'(dut.drop_q), 64'd3);
        gnt_pct = 100;
        repeat (30) step();
        chk("t3_cons_enough", 64'(cons_log.size() >= 2), 64'd1);
        if (cons_log.size() >= 2) begin
            chk("t3_pc0", cons_log[0].pc, 64'h1000);
            chk("t3_pc1", cons_log[1].pc, 64'h1004);
        end
        chk("t3_drop_zero", 64'(dut.drop_q), 64'd0);
        $display("T3 redirect-drop done step=%0d", stepn);

        // T4: redirect coincident with grant and pop; T7: fetch address wrap
        do_reset();
        redirect_seq("t4", 64'h2000);
        $display("T4 redirect-grant-pop done step=%0d", stepn);
        redirect_seq("t7", 64'hFFFF_FFFF_FFFF_FFF9);
        $display("T7 wrap done step=%0d", stepn);

        // T5: random grants and latencies over 1000 instructions
        do_reset();
        gnt_pct = 30; rdy_pct = 70; lat_min = 1; lat_max = 8;
        guard = 0;
        while (cons_log.size() < 1000 && guard < 40000) begin
            step();
            guard++;
        end
        chk("t5_count_reached", 64'(cons_log.size() >= 1000), 64'd1);
        bad = 0;
        for (int i = 1; i < cons_log.size(); i++) if (cons_log[i].pc != cons_log[i - 1].pc + 64'd4) bad++;
        chk("t5_seq_breaks", 64'(bad), 64'd0);
        if (cons_log.size() > 0) chk("t5_first_pc", cons_log[0].pc, RESET_PC);
        $display("T5 random done step=%0d consumed=%0d", stepn, cons_log.size());

        // T6: asynchronous reset mid-stream with two requests in flight
        do_reset();
        gnt_pct = 100; rdy_pct = 100; lat_min = 5; lat_max = 5;
        repeat (3) step();
        chk("t6_outstanding", 64'(dut.outst_q), 64'd2);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_req", 64'(imem_req_o), 64'd0);
        chk("t6_addr", imem_addr_o, RESET_PC);
        chk("t6_valid", 64'(instr_valid_o), 64'd0);
        chk("t6_instr", 64'(instr_o), 64'd0);
        chk("t6_pc", pc_o, 64'd0);
        chk("t6_outst_zero", 64'(dut.outst_q), 64'd0);
        do_reset();
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        repeat (10) step();
        chk("t6_cons_enough", 64'(cons_log.size() >= 2), 64'd1);
        if (cons_log.size() >= 2) begin
            chk("t6_restart_pc0", cons_log[0].pc, RESET_PC);
            chk("t6_restart_pc1", cons_log[1].pc, RESET_PC + 64'd4);
        end
        $display("T6 async reset done step=%0d", stepn);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rv_fetch_buf.md
RV_FETCH_BUF -- requirements
Module: rv_fetch_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of instruction-buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 64'h0, meaning the first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1, meaning reset; asynchronous, active-low.
REQ-005 SHALL have port redirect_i, input, 1, meaning the core requests a fetch restart (taken branch or mispredict).
REQ-006 SHALL have port redirect_pc_i, input, 64, meaning the restart address.
REQ-007 SHALL have port imem_req_o, output, 1, meaning a fetch request to instruction memory.
REQ-008 SHALL have port imem_addr_o, output, 64, meaning the fetch address.
REQ-009 SHALL have port imem_gnt_i, input, 1, meaning the request is accepted this cycle.
REQ-010 SHALL have port imem_rvalid_i, input, 1, meaning response data is valid; responses are in order, at least 1 cycle after grant.
REQ-011 SHALL have port imem_rdata_i, input, 32, meaning the response instruction word.
REQ-012 SHALL have port instr_valid_o, output, 1, meaning the buffer head holds a valid instruction.
REQ-013 SHALL have port instr_o, output, 32, meaning the head instruction.
REQ-014 SHALL have port pc_o, output, 64, meaning the head instruction's address.
REQ-015 SHALL have port instr_ready_i, input, 1, meaning the IF stage consumes the head (low = stall).

Function
REQ-016 SHALL drive imem_req_o high only when outstanding + occupancy < DEPTH, so the buffer never overflows.
REQ-017 SHALL hold imem_addr_o stable while imem_req_o is high and imem_gnt_i is low.
REQ-018 SHALL advance the fetch address by 4 on each grant, wrapping modulo 2^64.
REQ-019 SHALL push {addr, rdata} into the buffer on each non-stale imem_rvalid_i; instr_valid_o rises the cycle after the push (no bypass).
REQ-020 SHALL pop the head when instr_valid_o and instr_ready_i are both high; push and pop in the same cycle leave occupancy unchanged.
REQ-021 SHALL, on redirect_i, set the fetch address to {redirect_pc_i[63:2], 2'b00}, empty the buffer, and deassert instr_valid_o the next cycle.
REQ-022 SHALL, on redirect_i, load a drop counter with all outstanding requests, including any granted in the same cycle.
REQ-023 SHALL discard the next drop-counter responses, decrementing the counter on each, and SHALL NOT push them.
REQ-024 SHALL be able to issue a request to the redirect address in the cycle after redirect_i, provided credits allow.
REQ-025 SHALL let redirect_i take priority over pop and push in the same cycle.
REQ-026 SHALL size outstanding and drop counters to hold DEPTH without wrap; a response with zero outstanding is an assertion failure.
REQ-027 SHALL use a two-state FSM: BOOT (one cycle after reset, imem_req_o low) then FETCH; FETCH is never left except by reset.

Reset
REQ-028 SHALL, while rstn is low, force imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, pc_o=0, occupancy/outstanding/drop=0, state=BOOT.
REQ-029 SHALL, on reset mid-operation, forget in-flight requests; the memory side is reset by the same rstn.

Structure
REQ-030 SHALL take XLEN=64, ILEN=32 and the FSM state encoding from shared package rv_pkg.
REQ-031 SHALL implement storage as one sub-module rv_sync_fifo (parameterised width/depth, flush input, full/empty/count outputs).

Verification
REQ-032 Reset, 1-cycle-latency memory, ready=1 -> first req at 0x0 in cycle 2; instr_valid_o with pc_o=0x0,0x4,0x8 on consecutive cycles.
REQ-033 instr_ready_i=0 for 20 cycles, DEPTH=4 -> exactly 4 grants, then imem_req_o=0; occupancy 4; no lost or duplicated pc_o after release.
REQ-034 3 outstanding with 5-cycle latency, redirect to 0x1002 -> next addr 0x1000; the 3 old responses are dropped; first pc_o=0x1000.
REQ-035 redirect_i coincident with a grant and a pop -> buffer empty next cycle; that grant's response is dropped; drop counter returns to 0.
REQ-036 imem_gnt_i random 30% and rvalid latency random 1-8, 1000 instructions -> pc_o strictly +4 sequence and no overflow assertion.
REQ-037 rstn pulsed low mid-stream with 2 outstanding -> all outputs are reset values asynchronously; restart from RESET_PC.
